// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction loader: instruction kinds, MIPS
// opcodes, loader FSM states and the field-to-word encoder.
package instr_loader_pkg;

  typedef enum logic [2:0] {
    KIND_R    = 3'd0,
    KIND_LW   = 3'd1,
    KIND_SW   = 3'd2,
    KIND_ADDI = 3'd3,
    KIND_BEQ  = 3'd4,
    KIND_J    = 3'd5
  } kind_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Kinds 6 and 7 have no encoding and become a NOP word.
  function automatic logic kind_illegal(input logic [2:0] kind);
    return (kind > 3'd5);
  endfunction

  // Packs decoded fields into a MIPS word; shamt is always zero.
  function automatic logic [31:0] encode_instr(
    input logic [2:0]  kind,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [5:0]  funct,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [31:0] w;
    case (kind_e'(kind))
      KIND_R:    w = {OP_RTYPE, rs, rt, rd, 5'd0, funct};
      KIND_LW:   w = {OP_LW, rs, rt, imm};
      KIND_SW:   w = {OP_SW, rs, rt, imm};
      KIND_ADDI: w = {OP_ADDI, rs, rt, imm};
      KIND_BEQ:  w = {OP_BEQ, rs, rt, imm};
      KIND_J:    w = {OP_J, target};
      default:   w = 32'h0000_0000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instr_loader_fifo.sv
// Synchronous word FIFO between the encoder and the memory write port.
// Push is ignored when full and pop is ignored when empty.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  // Pointer and occupancy update; simultaneous push/pop keeps the count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/instr_loader.sv
// Instruction loader: encodes field bundles into MIPS words, buffers them and
// writes them to consecutive instruction-memory addresses while holding the
// CPU in reset. Optional illegal-kind reporting is enabled by defining
// INSTR_LOADER_CHECK_EN; otherwise err is tied low.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int AW        = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  input  logic [2:0]    in_kind,
  input  logic [4:0]    in_rs,
  input  logic [4:0]    in_rt,
  input  logic [4:0]    in_rd,
  input  logic [5:0]    in_funct,
  input  logic [15:0]   in_imm,
  input  logic [25:0]   in_target,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [31:0]   im_wdata,
  input  logic          im_ready,
  output logic          cpu_hold,
  output logic          done,
  output logic          ovf,
  output logic          err
);
  localparam logic [AW-1:0] BASE      = AW'(BASE_ADDR);
  localparam logic [AW:0]   ADDR_STEP = (AW+1)'(4);

  state_e        state_q, state_d;
  logic          im_we_q, im_we_d;
  logic [AW-1:0] im_addr_q, im_addr_d;
  logic [31:0]   im_wdata_q, im_wdata_d;
  logic          cpu_hold_q, cpu_hold_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;

  logic [31:0]   enc_word, fifo_rdata;
  logic [AW:0]   addr_sum;
  logic          hs, wr_done, out_free, active;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty, bypass;

  assign enc_word = encode_instr(in_kind, in_rs, in_rt, in_rd, in_funct, in_imm, in_target);
  assign in_ready = (state_q == ST_LOAD) && !fifo_full;
  assign hs       = in_valid && in_ready;
  assign wr_done  = im_we_q && im_ready;
  // Output register can take a new word if idle or its word leaves this cycle.
  assign out_free = !im_we_q || im_ready;
  assign active   = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
  assign fifo_pop = active && !fifo_empty && out_free;
  // An empty FIFO is skipped so a bundle reaches memory the next cycle.
  assign bypass    = hs && fifo_empty && out_free;
  assign fifo_push = hs && !bypass;
  assign addr_sum  = {1'b0, im_addr_q} + ADDR_STEP;

  instr_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (enc_word),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state for the FSM, write port and status flags.
  always_comb begin
    state_d    = state_q;
    im_we_d    = im_we_q;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;

    if (wr_done) begin
      im_addr_d = addr_sum[AW-1:0];
      if (addr_sum[AW]) ovf_d = 1'b1;
    end

    if (fifo_pop) begin
      im_we_d    = 1'b1;
      im_wdata_d = fifo_rdata;
    end else if (bypass) begin
      im_we_d    = 1'b1;
      im_wdata_d = enc_word;
    end else if (wr_done) begin
      im_we_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_LOAD;
          im_addr_d = BASE;
          ovf_d     = 1'b0;
        end
      end
      ST_LOAD: begin
        if (hs && in_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Last word is leaving now (or already gone) and nothing is queued.
        if (fifo_empty && out_free) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    cpu_hold_d = (state_d != ST_IDLE);
  end

  // Registered state and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      im_we_q    <= 1'b0;
      im_addr_q  <= BASE;
      im_wdata_q <= '0;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

  assign im_we    = im_we_q;
  assign im_addr  = im_addr_q;
  assign im_wdata = im_wdata_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign ovf      = ovf_q;

`ifdef INSTR_LOADER_CHECK_EN
  logic err_q, err_d;

  // Sticky illegal-kind flag, cleared when a new load starts.
  always_comb begin
    err_d = err_q;
    if (state_q == ST_IDLE && start) err_d = 1'b0;
    else if (hs && kind_illegal(in_kind)) err_d = 1'b1;
  end

  // Illegal-kind flag register.
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader. A second instance with AW=4 shares the
// stimulus to exercise address wrap-around.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_last, im_ready;
  logic [2:0]  in_kind;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic [25:0] in_target;

  logic        in_ready, im_we, cpu_hold, done, ovf, err;
  logic [9:0]  im_addr;
  logic [31:0] im_wdata;

  logic        s_in_ready, s_im_we, s_cpu_hold, s_done, s_ovf, s_err;
  logic [3:0]  s_im_addr;
  logic [31:0] s_im_wdata;

  int ncmp  = 0;
  int nfail = 0;

  typedef struct {
    logic [31:0] w;
    logic [9:0]  a;
    bit          last;
  } exp_t;
  exp_t sb[$];
  logic [9:0] exp_addr = '0;

`ifdef INSTR_LOADER_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  always #5 clk = ~clk;

  instr_loader #(.DEPTH(4), .AW(10), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .im_we(im_we),
    .im_addr(im_addr), .im_wdata(im_wdata), .im_ready(im_ready), .cpu_hold(cpu_hold),
    .done(done), .ovf(ovf), .err(err)
  );

  instr_loader #(.DEPTH(4), .AW(4), .BASE_ADDR(0)) dut_s (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_last(in_last), .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .im_we(s_im_we),
    .im_addr(s_im_addr), .im_wdata(s_im_wdata), .im_ready(im_ready), .cpu_hold(s_cpu_hold),
    .done(s_done), .ovf(s_ovf), .err(s_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every completed write.
  logic        done_exp = 1'b0;
  logic        stall_v  = 1'b0;
  logic [9:0]  stall_a;
  logic [31:0] stall_d;
  always @(negedge clk) begin
    if (rst) begin
      done_exp = 1'b0;
      stall_v  = 1'b0;
    end else begin
      if (done || done_exp) check("done_pulse", done, done_exp);
      done_exp = 1'b0;
      if (stall_v && im_we) begin
        check("stall_addr_stable", im_addr, stall_a);
        check("stall_data_stable", im_wdata, stall_d);
      end
      if (im_we && im_ready) begin
        stall_v = 1'b0;
        if (sb.size() == 0) begin
          check("unexpected_write", 1'b1, 1'b0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("wdata", im_wdata, e.w);
          check("waddr", im_addr, e.a);
          check("small_we", s_im_we, 1'b1);
          check("small_waddr", s_im_addr, e.a[3:0]);
          check("small_wdata", s_im_wdata, e.w);
          if (e.last) done_exp = 1'b1;
        end
      end else if (im_we) begin
        stall_v = 1'b1;
        stall_a = im_addr;
        stall_d = im_wdata;
      end else begin
        stall_v = 1'b0;
      end
    end
  end

  task automatic do_start(input string name);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    exp_addr = '0;
    check({name, "_in_ready_up"}, in_ready, 1'b1);
    check({name, "_hold_up"}, cpu_hold, 1'b1);
  endtask

  task automatic push(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [5:0] f, input logic [15:0] imm,
                      input logic [25:0] tg, input logic last, input logic [31:0] exp_w);
    int t = 0;
    exp_t e;
    in_valid = 1'b1; in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd;
    in_funct = f; in_imm = imm; in_target = tg; in_last = last;
    @(negedge clk);
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    if (!in_ready) begin
      check("push_timeout", in_ready, 1'b1);
    end else begin
      e.w = exp_w; e.a = exp_addr; e.last = last;
      sb.push_back(e);
      exp_addr = exp_addr + 10'd4;
    end
    @(posedge clk); #1 in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    @(negedge clk);
    while (!done && t < 300) begin @(negedge clk); t++; end
    check({name, "_done_seen"}, done, 1'b1);
    check({name, "_hold_in_done"}, cpu_hold, 1'b1);
    @(negedge clk);
    check({name, "_hold_off"}, cpu_hold, 1'b0);
    check({name, "_ready_off"}, in_ready, 1'b0);
    check({name, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic check_reset(input string name);
    check({name, "_we"}, im_we, 1'b0);
    check({name, "_addr"}, im_addr, 10'h000);
    check({name, "_wdata"}, im_wdata, 32'h0);
    check({name, "_hold"}, cpu_hold, 1'b0);
    check({name, "_done"}, done, 1'b0);
    check({name, "_ovf"}, ovf, 1'b0);
    check({name, "_err"}, err, 1'b0);
    check({name, "_ready"}, in_ready, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; im_ready = 1'b1;
    in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_funct = '0; in_imm = '0; in_target = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset("reset");

    // Single R-type: add $3,$1,$2
    do_start("t1");
    push(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 26'h0, 1'b1, 32'h0022_1820);
    wait_done("t1");

    // Mixed I/J formats
    do_start("t2");
    push(3'd1, 5'd1, 5'd2, 5'd0, 6'h0, 16'h0004, 26'h0, 1'b0, 32'h8C22_0004);
    push(3'd2, 5'd1, 5'd2, 5'd0, 6'h0, 16'h0008, 26'h0, 1'b0, 32'hAC22_0008);
    push(3'd4, 5'd1, 5'd2, 5'd0, 6'h0, 16'hFFFF, 26'h0, 1'b0, 32'h1022_FFFF);
    push(3'd5, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h10, 1'b1, 32'h0800_0010);
    wait_done("t2");
    check("t2_ovf", ovf, 1'b0);

    // Back-pressure: memory stalled until the FIFO fills; 6 words wrap AW=4
    im_ready = 1'b0;
    do_start("t3");
    for (int k = 1; k <= 5; k++)
      push(3'd3, 5'd0, 5'd1, 5'd0, 6'h0, 16'(k), 26'h0, 1'b0, 32'h2001_0000 | 32'(k));
    @(negedge clk);
    check("t3_ready_full", in_ready, 1'b0);
    check("t3_hold", cpu_hold, 1'b1);
    repeat (3) @(posedge clk);
    #1 im_ready = 1'b1;
    push(3'd3, 5'd0, 5'd1, 5'd0, 6'h0, 16'h6, 26'h0, 1'b1, 32'h2001_0006);
    wait_done("t3");
    check("t3_small_ovf", s_ovf, 1'b1);
    check("t3_ovf", ovf, 1'b0);

    // Illegal kinds encode NOP; start clears ovf
    do_start("t4");
    check("t4_small_ovf_clr", s_ovf, 1'b0);
    push(3'd7, 5'd3, 5'd4, 5'd5, 6'h3F, 16'h1234, 26'h3FF_FFFF, 1'b0, 32'h0);
    push(3'd6, 5'd1, 5'd1, 5'd1, 6'h01, 16'h0001, 26'h1, 1'b1, 32'h0);
    wait_done("t4");
    check("t4_err", err, EXP_ERR);
    check("t4_small_err", s_err, EXP_ERR);

    // Reset mid-load with a write pending
    do_start("t5");
    check("t5_err_clr", err, 1'b0);
    push(3'd3, 5'd0, 5'd1, 5'd0, 6'h0, 16'h7, 26'h0, 1'b0, 32'h2001_0007);
    push(3'd3, 5'd0, 5'd1, 5'd0, 6'h0, 16'h8, 26'h0, 1'b0, 32'h2001_0008);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 im_ready = 1'b0;
    push(3'd3, 5'd0, 5'd1, 5'd0, 6'h0, 16'h9, 26'h0, 1'b0, 32'h2001_0009);
    @(negedge clk);
    check("t5_pending_we", im_we, 1'b1);
    check("t5_pending_addr", im_addr, 10'h008);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    sb.delete();
    check_reset("t5_abort");
    im_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("t5_no_write", im_we, 1'b0);
    do_start("t6");
    push(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 26'h0, 1'b1, 32'h0022_1820);
    wait_done("t6");

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

Sequential instruction encoder and loader for the single-cycle/pipelined MIPS core. Accepts decoded instruction fields (kind, registers, funct, immediate, jump target) over a valid/ready stream, packs them into 32-bit MIPS words using the same opcode set the main control decoder recognises, buffers them, and writes them into instruction memory at consecutive word addresses. While loading, it holds the CPU in reset, so a bench or debug host can place a program in memory before execution.

## Interface
Parameters:
- DEPTH, 4: FIFO entries (power of two, ≥2).
- AW, 10: instruction-memory byte-address width.
- BASE_ADDR, 0: first write address (word aligned).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  bundle accepted when in_valid & in_ready.
- in_last  in  1  marks the final instruction of the program.
- in_kind  in  3  0=R, 1=lw, 2=sw, 3=addi, 4=beq, 5=j, 6/7 illegal.
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_funct  in  6  R-format funct; shamt is always encoded as 0.
- in_imm  in  16  I-format immediate.
- in_target  in  26  J-format target.
- im_we  out  1  instruction-memory write strobe.
- im_addr  out  AW  byte address, advanced by 4 per write.
- im_wdata  out  32  encoded word.
- im_ready  in  1  memory accepts the write this cycle; when low, im_we/im_addr/im_wdata are held.
- cpu_hold  out  1  CPU reset request while a load is in progress.
- done  out  1  one-cycle pulse at load completion.
- ovf  out  1  sticky: address wrapped; cleared by start.
- err  out  1  sticky illegal-kind flag; see Configuration.

## Operation
- Encoding: R = {000000, rs, rt, rd, 00000, funct}; lw = {100011, rs, rt, imm}; sw = {101011, rs, rt, imm}; addi = {001000, rs, rt, imm}; beq = {000100, rs, rt, imm}; j = {000010, target}; illegal kinds → 32'h0000_0000 (NOP).
- Encoding is combinational on input fields; the encoded word is pushed into the FIFO on handshake.
- FSM:
  - IDLE: in_ready=0, cpu_hold=0. start → LOAD, im_addr←BASE_ADDR, ovf←0, err←0.
  - LOAD: in_ready = !full; cpu_hold=1. A handshake with in_last=1 → DRAIN.
  - DRAIN: in_ready=0; continue draining. FIFO empty and no write pending → DONE.
  - DONE: done=1, cpu_hold=1 for this cycle → IDLE.
- Drain: when the FIFO is non-empty and either no write is pending or im_ready=1, pop the head into the output register and assert im_we. A pending write completes on im_we & im_ready, after which im_addr += 4.
- Address arithmetic is modulo 2^AW. An increment past the top wraps to 0 and sets ovf.
- A simultaneous push and pop on a full FIFO is not possible (in_ready=0). On a non-full FIFO, a push and pop in the same cycle leaves the count unchanged.
- start outside IDLE is ignored.

## Timing
- Reset values: state IDLE, FIFO empty, in_ready=0, im_we=0, im_addr=BASE_ADDR, im_wdata=0, cpu_hold=0, done=0, ovf=0, err=0.
- Reset mid-load aborts immediately: FIFO contents are discarded, no further writes occur, and cpu_hold drops the next cycle.
- Latency: a bundle accepted in cycle N appears with im_we=1 in cycle N+1 at the earliest (FIFO empty, im_ready=1).
- Throughput: 1 word/cycle with im_ready held high.
- in_ready rises the cycle after start.
- done fires exactly one cycle after the last write completes.

## Configuration
- INSTR_LOADER_CHECK_EN:
  - Defined: an illegal in_kind sets err (sticky until start or rst). Still encodes NOP.
  - Undefined: err is tied 0. Illegal kinds silently encode NOP.

## Structure
- Package instr_loader_pkg holds:
  - kind enum (KIND_R..KIND_J);
  - opcode constants OP_RTYPE=6'b000000, OP_LW=6'b100011, OP_SW=6'b101011, OP_ADDI=6'b001000, OP_BEQ=6'b000100, OP_J=6'b000010;
  - FSM state typedef.
- One sub-module, instr_fifo: synchronous FIFO (DEPTH, width 32) with push/pop/full/empty.

## Test plan
- start; push add $3,$1,$2 (kind 0, funct 0x20, in_last=1) → im_wdata=0x00221820 at im_addr 0x000, then done, cpu_hold falls.
- Push lw $2,4($1); sw $2,8($1); beq $1,$2,-1; j 0x10 (last) → writes 0x8C220004, 0xAC220008, 0x1022FFFF, 0x08000010 at addresses 0x0/0x4/0x8/0xC.
- Hold im_ready=0 and push 5 words with DEPTH=4 → in_ready drops once the FIFO is full. Release im_ready → all words are written in order; im_addr/im_wdata are stable while stalled.
- AW=4 with 5 writes → the 5th write lands at 0x0 and ovf=1. The next start clears ovf.
- in_kind=7 → word 0x00000000 written; err=1 with INSTR_LOADER_CHECK_EN defined, 0 without.
- Assert rst during LOAD after 2 of 4 words → no further im_we, all outputs reach reset values the next cycle, and start afterwards reloads from BASE_ADDR.
